// File: rtl/alu_exec_if.sv
// Request/response bundle between the issue logic and the alu_exec execute-stage ALU.
// The issuer owns the master modport and the ALU owns the slave modport.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             lt;
  logic             div_by_zero;
  logic             illegal;

  modport master (
    output start, alu_ctrl, op_a, op_b,
    input  ready, done, result, result_hi, zero, lt, div_by_zero, illegal
  );

  modport slave (
    input  start, alu_ctrl, op_a, op_b,
    output ready, done, result, result_hi, zero, lt, div_by_zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle add/sub/logic/shift/rotate, iterative shift-add multiply and,
// when ALU_DIV_EN is defined, an iterative restoring divider; otherwise code 0010 is illegal.
module alu_exec #(
  parameter int unsigned WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  alu_exec_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] StDiv  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // hi/lo hold the running product, or remainder/quotient while dividing.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
  logic             ltp_q, ltp_d;

  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic             zero_q, zero_d, lt_q, lt_d, dbz_q, dbz_d, ill_q, ill_d;

  logic             fin;
  logic [WIDTH-1:0] r_new, rh_new;
  logic             lt_new, dbz_new, ill_new, lt_now;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_sh, rem_sub;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    ltp_d    = ltp_q;
    done_d   = 1'b0;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    fin      = 1'b0;
    r_new    = '0;
    rh_new   = '0;
    lt_new   = 1'b0;
    dbz_new  = 1'b0;
    ill_new  = 1'b0;
    lt_now   = $signed(bus.op_a) < $signed(bus.op_b);
    sh       = bus.op_b[SHW-1:0];
    mul_sum  = '0;
`ifdef ALU_DIV_EN
    rem_sh   = '0;
    rem_sub  = '0;
`endif

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          fin    = 1'b1;
          lt_new = lt_now;
          case (bus.alu_ctrl)
            4'b1111: r_new = bus.op_a + bus.op_b;
            4'b1110: r_new = bus.op_a - bus.op_b;
            4'b1101: r_new = bus.op_a & bus.op_b;
            4'b1100: r_new = bus.op_a | bus.op_b;
            4'b1010: r_new = bus.op_a << sh;
            4'b1011: r_new = bus.op_a >> sh;
            // Shift by WIDTH yields zero, so a zero amount rotates to op_a unchanged.
            4'b1000: r_new = (bus.op_a << sh) | (bus.op_a >> (WIDTH - 32'(sh)));
            4'b1001: r_new = (bus.op_a >> sh) | (bus.op_a << (WIDTH - 32'(sh)));
            4'b0001: begin
              fin     = 1'b0;
              state_d = StMul;
              cnt_d   = '0;
              hi_d    = '0;
              lo_d    = bus.op_b;
              opd_d   = bus.op_a;
              ltp_d   = lt_now;
            end
`ifdef ALU_DIV_EN
            4'b0010: begin
              if (bus.op_b == '0) begin
                r_new   = '1;
                rh_new  = bus.op_a;
                dbz_new = 1'b1;
              end else begin
                fin     = 1'b0;
                state_d = StDiv;
                cnt_d   = '0;
                hi_d    = '0;
                lo_d    = bus.op_a;
                opd_d   = bus.op_b;
                ltp_d   = lt_now;
              end
            end
`endif
            default: ill_new = 1'b1;
          endcase
        end
      end

      StMul: begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        hi_d    = mul_sum[WIDTH:1];
        lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          fin     = 1'b1;
          state_d = StIdle;
          r_new   = lo_d;
          rh_new  = hi_d;
          lt_new  = ltp_q;
        end
      end

`ifdef ALU_DIV_EN
      StDiv: begin
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        if (rem_sh >= {1'b0, opd_q}) begin
          rem_sub = rem_sh - {1'b0, opd_q};
          hi_d    = rem_sub[WIDTH-1:0];
          lo_d    = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d    = rem_sh[WIDTH-1:0];
          lo_d    = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          fin     = 1'b1;
          state_d = StIdle;
          r_new   = lo_d;
          rh_new  = hi_d;
          lt_new  = ltp_q;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    if (fin) begin
      done_d   = 1'b1;
      res_d    = r_new;
      res_hi_d = rh_new;
      zero_d   = (r_new == '0);
      lt_d     = lt_new;
      dbz_d    = dbz_new;
      ill_d    = ill_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      ltp_q    <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opd_q    <= opd_d;
      ltp_q    <= ltp_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  assign bus.ready       = (state_q == StIdle);
  assign bus.done        = done_q;
  assign bus.result      = res_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.zero        = zero_q;
  assign bus.lt          = lt_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec; expectations for code 0010 follow ALU_DIV_EN.
module tb_alu_exec;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;
  int   nrdy;
  int   ndone;

  alu_exec_if #(.WIDTH(16)) bus ();

  alu_exec #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op; lat is the cycle (after acceptance) in which done is seen, 0 on timeout.
  task automatic run_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                        output int l);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    l = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        l = n;
        break;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.start = 1'b0;
    bus.alu_ctrl = 4'b0000;
    bus.op_a = '0;
    bus.op_b = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {28'd0, bus.zero, bus.lt, bus.div_by_zero, bus.illegal}, 32'd0);
    rst = 1'b1;

    run_op(4'b1111, 16'hFFFF, 16'h0001, lat);
    check("add_lat", 32'(lat), 32'd1);
    check("add_res", 32'(bus.result), 32'h0000);
    check("add_hi", 32'(bus.result_hi), 32'h0000);
    check("add_zero", 32'(bus.zero), 32'd1);
    check("add_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check("add_done_pulse", 32'(bus.done), 32'd0);
    check("add_hold", 32'(bus.zero), 32'd1);

    run_op(4'b1110, 16'h0003, 16'h0005, lat);
    check("sub_res", 32'(bus.result), 32'hFFFE);
    check("sub_flags", {30'd0, bus.lt, bus.zero}, 32'b10);

    // Multiply with an ignored start pulse in cycle 5.
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_ctrl = 4'b0001;
    bus.op_a = 16'h1234;
    bus.op_b = 16'h0100;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    nrdy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.ready) nrdy++;
      if (n == 5) begin
        bus.start = 1'b1;
        bus.alu_ctrl = 4'b1111;
        bus.op_a = 16'h0001;
        bus.op_b = 16'h0001;
      end else begin
        bus.start = 1'b0;
        bus.op_a = 16'hAAAA;
        bus.op_b = 16'h5555;
      end
    end
    bus.start = 1'b0;
    check("mul_lat", 32'(lat), 32'd17);
    check("mul_busy", 32'(nrdy), 32'd16);
    check("mul_ready_at_done", 32'(bus.ready), 32'd1);
    check("mul_prod", {bus.result_hi, bus.result}, 32'h0012_3400);
    check("mul_lt", 32'(bus.lt), 32'd0);
    @(negedge clk);
    check("mul_no_extra_done", 32'(bus.done), 32'd0);

    run_op(4'b0010, 16'd100, 16'd7, lat);
`ifdef ALU_DIV_EN
    check("div_lat", 32'(lat), 32'd17);
    check("div_qr", {bus.result_hi, bus.result}, {16'd2, 16'd14});
    check("div_ill", 32'(bus.illegal), 32'd0);
`else
    check("div_lat", 32'(lat), 32'd1);
    check("div_qr", {bus.result_hi, bus.result}, 32'd0);
    check("div_ill", 32'(bus.illegal), 32'd1);
`endif

    run_op(4'b0010, 16'd5, 16'd0, lat);
    check("dbz_lat", 32'(lat), 32'd1);
`ifdef ALU_DIV_EN
    check("dbz_res", {bus.result_hi, bus.result}, {16'd5, 16'hFFFF});
    check("dbz_flags", {30'd0, bus.div_by_zero, bus.illegal}, 32'b10);
`else
    check("dbz_res", {bus.result_hi, bus.result}, 32'd0);
    check("dbz_flags", {30'd0, bus.div_by_zero, bus.illegal}, 32'b01);
`endif

    run_op(4'b1000, 16'h8001, 16'h0001, lat);
    check("rol", 32'(bus.result), 32'h0003);
    run_op(4'b1001, 16'h8001, 16'h0004, lat);
    check("ror", 32'(bus.result), 32'h1800);
    run_op(4'b1011, 16'h8000, 16'h000F, lat);
    check("srl", 32'(bus.result), 32'h0001);
    run_op(4'b1001, 16'h1234, 16'h0010, lat);
    check("ror_zero_amt", 32'(bus.result), 32'h1234);
    run_op(4'b0111, 16'h1234, 16'h5678, lat);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_res", {bus.result_hi, bus.result}, 32'd0);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    run_op(4'b1010, 16'h0001, 16'h0013, lat);
    check("sll", 32'(bus.result), 32'h0008);
    check("sll_ill_clear", 32'(bus.illegal), 32'd0);

    // Reset in cycle 8 of a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_ctrl = 4'b0001;
    bus.op_a = 16'h00FF;
    bus.op_b = 16'h00FF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_mul_busy", 32'(bus.ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_out", {bus.result_hi, bus.result}, 32'd0);
    check("arst_flags", {27'd0, bus.done, bus.zero, bus.lt, bus.div_by_zero, bus.illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("arst_no_done", 32'(ndone), 32'd0);

    run_op(4'b1100, 16'h00F0, 16'h000F, lat);
    check("or_lat", 32'(lat), 32'd1);
    check("or_res", 32'(bus.result), 32'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the 16-bit datapath. It sits directly downstream of the ALU control decoder and consumes its 4-bit `alu_ctrl` code together with two register operands. Add, subtract, logic, shift and rotate complete in one cycle. Multiply is an iterative shift-add and divide is an iterative restoring divider, both under a start/ready/done handshake. Branch flags are produced alongside every result.

## Interface
- `WIDTH`, 16: operand and result width; must be ≥ 4 and a power of 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `alu_ctrl`  in  4  operation code from the ALU control decoder.
- `op_a`  in  WIDTH  operand A; sampled at acceptance.
- `op_b`  in  WIDTH  operand B or shift amount; sampled at acceptance.
- `ready`  out  1  block is idle and able to accept.
- `done`  out  1  one-cycle pulse when the result registers update.
- `result`  out  WIDTH  low result, product low half, or quotient.
- `result_hi`  out  WIDTH  product high half or remainder; 0 for all other ops.
- `zero`  out  1  `result`==0.
- `lt`  out  1  signed `op_a` < signed `op_b`.
- `div_by_zero`  out  1  divide was attempted with `op_b`=0.
- `illegal`  out  1  unsupported `alu_ctrl` code.

## Operation
- Codes: 1111 add, 1110 sub, 1101 and, 1100 or, 0001 mul, 0010 div, 1010 sll, 1011 srl, 1000 rol, 1001 ror.
  - Loads and stores arrive as 1111; branches arrive as 1110.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on an accepted 0001.
  - IDLE → DIV on an accepted 0010 with `op_b`≠0.
  - Every other accepted op stays in IDLE.
  - MUL/DIV → IDLE after WIDTH iterations.
- Add and sub wrap modulo 2^WIDTH; no carry or overflow output.
- Shifts and rotates use only `op_b[$clog2(WIDTH)-1:0]`; upper bits are ignored.
  - srl fills with zeros.
  - Shift amount 0 passes `op_a` through.
- Mul is unsigned; the 2·WIDTH product is split across `{result_hi, result}`.
- Div is unsigned: quotient in `result`, remainder in `result_hi`.
- Divide by zero: no iteration; `result` = all ones, `result_hi` = `op_a`, `div_by_zero`=1.
- Unknown codes: `result` = 0, `result_hi` = 0, `illegal`=1.
- `zero` and `lt` are recomputed from the latched operands and result at every `done`, for all ops.
- `div_by_zero` and `illegal` update at every `done`; otherwise they are 0.
- All result and flag outputs hold their values between `done` pulses.

## Timing
- Reset values: `ready`=1, `done`=0; every other output 0; state IDLE.
- Reset takes effect immediately, including mid-iteration. Partial work is discarded; no `done` is issued for it.
- `start` is sampled at a rising edge while `ready`=1; call that cycle 0.
- Single-cycle ops, divide by zero and illegal codes: outputs update at the cycle-0 edge; `done`=1 in cycle 1; `ready` stays 1.
- Mul and div (`op_b`≠0):
  - `ready`=0 in cycles 1..WIDTH.
  - Outputs update and `done`=1 in cycle WIDTH+1, with `ready`=1 in that same cycle.
- Back-to-back ops: `start` may be high in the same cycle as `done`; the new op is accepted.
- `start` while `ready`=0 is ignored and not queued. Operand changes during iteration have no effect.

## Configuration
- Macro: `ALU_DIV_EN`.
- Defined: the divider datapath and DIV state are built; behaviour is as above.
- Undefined: no divider logic is built. Code 0010 is treated as illegal: `illegal`=1, `result` = 0, `done` in cycle 1.

## Test plan
- Add 0xFFFF + 0x0001 → `result` 0x0000, `zero`=1, `done` in cycle 1. Then sub 0x0003 − 0x0005 → 0xFFFE, `lt`=1, `zero`=0.
- Mul 0x1234 × 0x0100 → `result_hi` 0x0012, `result` 0x3400, `done` in cycle 17. `ready`=0 in cycles 1–16; a `start` pulse in cycle 5 is ignored.
- Div 100 ÷ 7 → `result` 14, `result_hi` 2, `done` in cycle 17. Div 5 ÷ 0 → `result` 0xFFFF, `result_hi` 5, `div_by_zero`=1, `done` in cycle 1.
- Shifts and rotates:
  - rol 0x8001 by 1 → 0x0003.
  - ror 0x8001 by 4 → 0x1800.
  - srl 0x8000 by 15 → 0x0001.
  - sll 0x0001 by 0x0013 (amount 3) → 0x0008.
- Reset asserted in cycle 8 of a mul:
  - All outputs go to 0 immediately and `ready`=1.
  - No `done` follows.
  - After release, or 0x00F0 | 0x000F → 0x00FF in cycle 1.
- Built without `ALU_DIV_EN`: div 100 ÷ 7 → `illegal`=1, `result` 0, `done` in cycle 1. Code 0111 gives `illegal`=1 in both builds.
